// File: rtl/serial_addsub_pkg.sv
// Shared types and state encodings for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock through a single
// full-adder cell, with valid/ready handshakes on operands and result.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   shift_a;
  logic [WIDTH-1:0]   shift_b;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;

  assign last_bit = (cnt == LAST_BIT);

  full_adder u_fa (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs are flops tracking the next state, so no input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_a <= a;
            shift_b <= sub ? ~b : b;
            carry   <= sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          sum     <= {fa_sum, sum[WIDTH-1:1]};
          carry   <= fa_cout;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout <= fa_cout;
            ovf  <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
